// File: rtl/uart_frame_parser_if.sv
// UART RX FIFO read port shared between the FIFO and the frame parser.
// The FIFO presents its head byte and empty flag; the parser returns the pop strobe.
interface uart_frame_parser_if;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;

  modport master (
    output r_data,
    output rx_empty,
    input  rd_uart
  );

  modport slave (
    input  r_data,
    input  rx_empty,
    output rd_uart
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Receive side of the inter-board game link.
// Pops bytes from the UART RX FIFO, hunts for the header byte, assembles a
// 6-byte payload, verifies the XOR checksum and publishes player-2 state and
// boss HP as registered outputs. Also tracks link health and error counts.
module uart_frame_parser #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         BYTE_TIMEOUT = 24000,
  parameter int         LINK_TIMEOUT = 4500000
) (
  input  logic                clk,
  input  logic                rst,
  uart_frame_parser_if.slave  fifo,
  output logic [11:0]         p2_x,
  output logic [11:0]         p2_y,
  output logic [3:0]          p2_hp,
  output logic [3:0]          p2_aggro,
  output logic                p2_flip_h,
  output logic [1:0]          p2_class,
  output logic                p2_game_start,
  output logic [6:0]          boss_hp_rx,
  output logic                frame_valid,
  output logic                link_up,
  output logic [7:0]          err_cnt
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int LT_W = $clog2(LINK_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [LT_W-1:0] LT_MAX  = LT_W'(LINK_TIMEOUT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            store_byte;
  logic            good_frame;
  logic            err_event;
  logic            byte_expire;
  logic [2:0]      idx;
  logic [7:0]      xor_acc;
  logic [47:0]     shadow;
  logic [BT_W-1:0] byte_timer;
  logic [LT_W-1:0] link_timer;
  logic            link_seen;
  logic            game_start_q;

  // Pop whenever the FIFO has data; reset holds the FIFO untouched.
  assign fifo.rd_uart = !fifo.rx_empty && !rst;
  assign accept       = fifo.rd_uart;
  assign byte_expire  = (byte_timer == BT_LAST);

  // Link is up only after a good frame and until the silence timer saturates.
  assign link_up       = link_seen && (link_timer != LT_MAX);
  assign p2_game_start = game_start_q && link_up;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; an accepted byte always takes priority over a timeout.
  always_comb begin
    state_next = state;
    store_byte = 1'b0;
    good_frame = 1'b0;
    err_event  = 1'b0;
    case (state)
      HUNT: begin
        if (accept && (fifo.r_data == HEADER)) begin
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          store_byte = 1'b1;
          if (idx == 3'd5) begin
            state_next = CHECK;
          end
        end else if (byte_expire) begin
          state_next = HUNT;
          err_event  = 1'b1;
        end
      end
      CHECK: begin
        if (accept) begin
          if (fifo.r_data == xor_acc) begin
            good_frame = 1'b1;
          end else begin
            err_event = 1'b1;
          end
          state_next = HUNT;
        end else if (byte_expire) begin
          state_next = HUNT;
          err_event  = 1'b1;
        end
      end
      default: begin
        state_next = HUNT;
      end
    endcase
  end

  // Payload assembly: bytes shift in so B0 ends up in the top byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 3'd0;
      xor_acc <= 8'd0;
      shadow  <= 48'd0;
    end else if (state == HUNT) begin
      idx     <= 3'd0;
      xor_acc <= 8'd0;
    end else if (store_byte) begin
      idx     <= idx + 3'd1;
      xor_acc <= xor_acc ^ fifo.r_data;
      shadow  <= {shadow[39:0], fifo.r_data};
    end
  end

  // Inter-byte timer; idle in HUNT, cleared by any accepted byte or a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_timer <= '0;
    end else if (accept || (state == HUNT) || (state_next == HUNT)) begin
      byte_timer <= '0;
    end else begin
      byte_timer <= byte_timer + 1'b1;
    end
  end

  // Publish a verified frame on the edge after its checksum byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid  <= 1'b0;
      p2_x         <= 12'd0;
      p2_y         <= 12'd0;
      p2_hp        <= 4'd0;
      p2_aggro     <= 4'd0;
      p2_flip_h    <= 1'b0;
      p2_class     <= 2'd0;
      game_start_q <= 1'b0;
      boss_hp_rx   <= 7'd0;
    end else begin
      frame_valid <= good_frame;
      if (good_frame) begin
        p2_x         <= shadow[47:36];
        p2_y         <= shadow[35:24];
        p2_hp        <= shadow[23:20];
        p2_aggro     <= shadow[19:16];
        p2_flip_h    <= shadow[15];
        p2_class     <= shadow[14:13];
        game_start_q <= shadow[12];
        boss_hp_rx   <= shadow[6:0];
      end
    end
  end

  // Saturating count of checksum failures and byte timeouts.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_event && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // Link silence timer; a good frame wins over simultaneous expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_timer <= '0;
      link_seen  <= 1'b0;
    end else if (good_frame) begin
      link_timer <= '0;
      link_seen  <= 1'b1;
    end else if (link_timer != LT_MAX) begin
      link_timer <= link_timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: table of frames with hand-computed
// expected outputs, plus sequences for timeouts, link loss and mid-frame reset.
module tb_uart_frame_parser;

  localparam int BT = 100;
  localparam int LT = 2000;

  logic        clk;
  logic        rst;
  logic [11:0] p2_x;
  logic [11:0] p2_y;
  logic [3:0]  p2_hp;
  logic [3:0]  p2_aggro;
  logic        p2_flip_h;
  logic [1:0]  p2_class;
  logic        p2_game_start;
  logic [6:0]  boss_hp_rx;
  logic        frame_valid;
  logic        link_up;
  logic [7:0]  err_cnt;

  int tests;
  int fails;

  uart_frame_parser_if fif ();

  uart_frame_parser #(
    .HEADER       (8'hA5),
    .BYTE_TIMEOUT (BT),
    .LINK_TIMEOUT (LT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo          (fif.slave),
    .p2_x          (p2_x),
    .p2_y          (p2_y),
    .p2_hp         (p2_hp),
    .p2_aggro      (p2_aggro),
    .p2_flip_h     (p2_flip_h),
    .p2_class      (p2_class),
    .p2_game_start (p2_game_start),
    .boss_hp_rx    (boss_hp_rx),
    .frame_valid   (frame_valid),
    .link_up       (link_up),
    .err_cnt       (err_cnt)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        garbage;
    logic [47:0] payload;
    logic [7:0]  chk_flip;
    logic        exp_valid;
    logic [11:0] x;
    logic [11:0] y;
    logic [3:0]  hp;
    logic [3:0]  aggro;
    logic        flip;
    logic [1:0]  cls;
    logic        start;
    logic [6:0]  boss;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs [5];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    fif.r_data   = b;
    fif.rx_empty = 1'b0;
    @(posedge clk);
    #1;
    fif.rx_empty = 1'b1;
  endtask

  function automatic logic [7:0] frame_chk(input logic [47:0] p);
    return p[47:40] ^ p[39:32] ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
  endfunction

  task automatic apply_stimulus(input logic [47:0] p, input logic [7:0] flip);
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) begin
      send_byte(p[47-8*i -: 8]);
    end
    send_byte(frame_chk(p) ^ flip);
  endtask

  task automatic check_fields(input vec_t v, input string tag);
    check_output({tag, " p2_x"},          32'(p2_x),          32'(v.x));
    check_output({tag, " p2_y"},          32'(p2_y),          32'(v.y));
    check_output({tag, " p2_hp"},         32'(p2_hp),         32'(v.hp));
    check_output({tag, " p2_aggro"},      32'(p2_aggro),      32'(v.aggro));
    check_output({tag, " p2_flip_h"},     32'(p2_flip_h),     32'(v.flip));
    check_output({tag, " p2_class"},      32'(p2_class),      32'(v.cls));
    check_output({tag, " p2_game_start"}, 32'(p2_game_start), 32'(v.start));
    check_output({tag, " boss_hp_rx"},    32'(boss_hp_rx),    32'(v.boss));
    check_output({tag, " err_cnt"},       32'(err_cnt),       32'(v.err));
  endtask

  vec_t f1;
  vec_t f3;

  initial begin
    tests = 0;
    fails = 0;
    rst          = 1'b1;
    fif.r_data   = 8'h00;
    fif.rx_empty = 1'b1;

    // Frame 1: checksum 12^34^56^7B^D0^2A = F1
    vecs[0] = '{1'b0, 48'h1234567BD02A, 8'h00, 1'b1, 12'h123, 12'h456, 4'h7, 4'hB, 1'b1, 2'd2, 1'b1, 7'h2A, 8'd0};
    // Corrupted checksum: outputs hold, one error
    vecs[1] = '{1'b0, 48'h1234567BD02A, 8'h01, 1'b0, 12'h123, 12'h456, 4'h7, 4'hB, 1'b1, 2'd2, 1'b1, 7'h2A, 8'd1};
    // Garbage preamble then a payload carrying the header value as data
    vecs[2] = '{1'b1, 48'hA50F0F3C207F, 8'h00, 1'b1, 12'hA50, 12'hF0F, 4'h3, 4'hC, 1'b0, 2'd1, 1'b0, 7'h7F, 8'd1};
    // Spare bits set in B4 low nibble and B5 bit 7 are ignored
    vecs[3] = '{1'b0, 48'h000001A19FFF, 8'h00, 1'b1, 12'h000, 12'h001, 4'hA, 4'h1, 1'b1, 2'd0, 1'b1, 7'h7F, 8'd1};
    // All-ones fields
    vecs[4] = '{1'b0, 48'hFFFFFFFF6F00, 8'h00, 1'b1, 12'hFFF, 12'hFFF, 4'hF, 4'hF, 1'b0, 2'd3, 1'b0, 7'h00, 8'd1};

    f1 = vecs[0];
    f3 = vecs[2];

    // Reset state and no popping while in reset
    idle(3);
    fif.r_data   = 8'hA5;
    fif.rx_empty = 1'b0;
    #1;
    check_output("rd_uart in reset", 32'(fif.rd_uart), 32'd0);
    check_output("reset p2_x", 32'(p2_x), 32'd0);
    check_output("reset frame_valid", 32'(frame_valid), 32'd0);
    check_output("reset link_up", 32'(link_up), 32'd0);
    check_output("reset err_cnt", 32'(err_cnt), 32'd0);
    check_output("reset boss_hp_rx", 32'(boss_hp_rx), 32'd0);
    fif.rx_empty = 1'b1;
    rst = 1'b0;
    idle(2);

    // Pop strobe follows the FIFO flag combinationally (byte dropped in HUNT)
    fif.r_data   = 8'h00;
    fif.rx_empty = 1'b0;
    #1;
    check_output("rd_uart when data", 32'(fif.rd_uart), 32'd1);
    @(posedge clk);
    #1;
    fif.rx_empty = 1'b1;
    #1;
    check_output("rd_uart when empty", 32'(fif.rd_uart), 32'd0);
    idle(2);

    // Table of frames
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].garbage) begin
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA4);
      end
      apply_stimulus(vecs[i].payload, vecs[i].chk_flip);
      check_output($sformatf("vec%0d frame_valid", i), 32'(frame_valid), 32'(vecs[i].exp_valid));
      check_fields(vecs[i], $sformatf("vec%0d", i));
      check_output($sformatf("vec%0d link_up", i), 32'(link_up), 32'd1);
      idle(1);
      check_output($sformatf("vec%0d pulse end", i), 32'(frame_valid), 32'd0);
      idle(3);
    end

    // Byte timeout mid-frame, then a good frame is still accepted
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(BT + 20);
    check_output("timeout err_cnt", 32'(err_cnt), 32'd2);
    apply_stimulus(f1.payload, 8'h00);
    check_output("after timeout frame_valid", 32'(frame_valid), 32'd1);
    f1.err = 8'd2;
    check_fields(f1, "after timeout");
    idle(3);

    // A gap just under the byte timeout does not break the frame
    send_byte(8'hA5);
    send_byte(8'h12);
    idle(BT - 10);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h7B);
    send_byte(8'hD0);
    send_byte(8'h2A);
    send_byte(8'hF1);
    check_output("slow frame frame_valid", 32'(frame_valid), 32'd1);
    check_output("slow frame err_cnt", 32'(err_cnt), 32'd2);

    // Link loss after silence: game_start forced low, other fields hold
    idle(LT - 10);
    check_output("link before expiry", 32'(link_up), 32'd1);
    check_output("start before expiry", 32'(p2_game_start), 32'd1);
    idle(20);
    check_output("link after expiry", 32'(link_up), 32'd0);
    check_output("start after expiry", 32'(p2_game_start), 32'd0);
    check_output("p2_x holds", 32'(p2_x), 32'h123);
    check_output("p2_hp holds", 32'(p2_hp), 32'h7);
    apply_stimulus(f1.payload, 8'h00);
    check_output("link restored", 32'(link_up), 32'd1);
    check_output("start restored", 32'(p2_game_start), 32'd1);
    idle(3);

    // Reset in the middle of a frame
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    rst          = 1'b1;
    fif.r_data   = 8'hA5;
    fif.rx_empty = 1'b0;
    #1;
    check_output("mid rst rd_uart", 32'(fif.rd_uart), 32'd0);
    idle(2);
    check_output("mid rst p2_x", 32'(p2_x), 32'd0);
    check_output("mid rst p2_game_start", 32'(p2_game_start), 32'd0);
    check_output("mid rst link_up", 32'(link_up), 32'd0);
    check_output("mid rst err_cnt", 32'(err_cnt), 32'd0);
    fif.rx_empty = 1'b1;
    rst = 1'b0;
    idle(2);
    apply_stimulus(f3.payload, 8'h00);
    check_output("post rst frame_valid", 32'(frame_valid), 32'd1);
    f3.err = 8'd0;
    check_fields(f3, "post rst");
    check_output("post rst link_up", 32'(link_up), 32'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
